// File: rtl/lane_congestion_estimator.sv
// lane_congestion_estimator
//   Turns per-lane loop-detector arrival/departure levels into saturating
//   queue-length estimates and derives, per lane, an occupancy flag and a
//   hysteretic congestion flag that is evaluated only on tick strobes.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   arrive     [3:0] per-lane arrival detector level
//   depart     [3:0] per-lane departure detector level
//   tick       single-cycle congestion-evaluation strobe
//   clear_ovf  clears all sticky overflow flags
//   queue_cnt  [4*CNT_W-1:0] lane i count at [i*CNT_W +: CNT_W]
//   occupied   [3:0] lane i count is nonzero
//   congested  [3:0] lane i hysteretic congestion flag
//   overflow   [3:0] sticky: lane i saw an arrival while saturated
module lane_congestion_estimator #(
  parameter int CNT_W      = 6,
  parameter int HI_THRESH  = 12,
  parameter int LO_THRESH  = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         arrive,
  input  logic [3:0]         depart,
  input  logic               tick,
  input  logic               clear_ovf,
  output logic [4*CNT_W-1:0] queue_cnt,
  output logic [3:0]         occupied,
  output logic [3:0]         congested,
  output logic [3:0]         overflow
);

  localparam int unsigned NL = 4;
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  HI        = CNT_W'(HI_THRESH);
  localparam logic [CNT_W-1:0]  LO        = CNT_W'(LO_THRESH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic {CLEAR, CONG} cong_state_t;

  logic [NL-1:0]     arrive_q, depart_q;
  logic [NL-1:0]     arr_ev, dep_ev;
  logic [CNT_W-1:0]  cnt_q [NL];
  logic [CNT_W-1:0]  cnt_d [NL];
  logic [NL-1:0]     ovf_q, ovf_d;
  cong_state_t       st_q [NL];
  cong_state_t       st_d [NL];
  logic [HOLD_W-1:0] hold_q [NL];
  logic [HOLD_W-1:0] hold_d [NL];

  // Rising-edge events; edge registers reset low so a level already high at
  // reset release counts once on the first clock.
  assign arr_ev = arrive & ~arrive_q;
  assign dep_ev = depart & ~depart_q;

  // Saturating count update and sticky overflow (a set beats clear_ovf).
  always_comb begin
    ovf_d = ovf_q & ~{NL{clear_ovf}};
    for (int unsigned i = 0; i < NL; i++) begin
      cnt_d[i] = cnt_q[i];
      if (arr_ev[i] && !dep_ev[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dep_ev[i] && !arr_ev[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Congestion hysteresis; thresholds compare the pre-update count.
  always_comb begin
    for (int unsigned i = 0; i < NL; i++) begin
      st_d[i]   = st_q[i];
      hold_d[i] = hold_q[i];
      if (tick) begin
        unique case (st_q[i])
          CLEAR: begin
            if (cnt_q[i] >= HI) begin
              if (hold_q[i] == HOLD_LAST) begin
                st_d[i]   = CONG;
                hold_d[i] = '0;
              end else begin
                hold_d[i] = hold_q[i] + 1'b1;
              end
            end else begin
              hold_d[i] = '0;
            end
          end
          CONG: begin
            if (cnt_q[i] <= LO) begin
              if (hold_q[i] == HOLD_LAST) begin
                st_d[i]   = CLEAR;
                hold_d[i] = '0;
              end else begin
                hold_d[i] = hold_q[i] + 1'b1;
              end
            end else begin
              hold_d[i] = '0;
            end
          end
          default: begin
            st_d[i]   = CLEAR;
            hold_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arrive_q <= '0;
      depart_q <= '0;
      ovf_q    <= '0;
      for (int unsigned i = 0; i < NL; i++) begin
        cnt_q[i]  <= '0;
        st_q[i]   <= CLEAR;
        hold_q[i] <= '0;
      end
    end else begin
      arrive_q <= arrive;
      depart_q <= depart;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < NL; i++) begin
        cnt_q[i]  <= cnt_d[i];
        st_q[i]   <= st_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  always_comb begin
    queue_cnt = '0;
    occupied  = '0;
    congested = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      queue_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
      occupied[i]                 = (cnt_q[i] != '0);
      congested[i]                = (st_q[i] == CONG);
    end
  end

  assign overflow = ovf_q;

endmodule
